snake_head_stepper: RTL and testbench

Consumer of the move-tick pulse produced by the game's rate divider. On each tick it advances the snake head one grid cell in the latched direction and detects wall collisions. It sequences an erase-old / draw-new request pair to the VGA plot engine over a req/ack handshake. It also drives the 2-bit speed select back to the rate divider, raising the level as moves accumulate.

---
 rtl/snake_head_stepper.sv | 125 ++++++++++++
 tb/tb_snake_head_stepper.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_head_stepper.sv
// rtl/snake_head_stepper.sv - snake head movement, wall collision and erase/draw plot sequencing
module snake_head_stepper #(
  parameter int GRID_W          = 40,
  parameter int GRID_H          = 30,
  parameter int START_X         = 20,
  parameter int START_Y         = 15,
  parameter int STEPS_PER_LEVEL = 16
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iTick,
  input  logic       iEnable,
  input  logic [3:0] iDir,
  input  logic       iDrawAck,
  output logic       oDrawReq,
  output logic [5:0] oX,
  output logic [4:0] oY,
  output logic       oColour,
  output logic [1:0] oSpeed,
  output logic       oGameOver
);

  localparam int CW = (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DEAD} state_t;
  // Opposite directions share bit 1 and differ in bit 0.
  typedef enum logic [1:0] {D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11} dir_t;

  state_t          state;
  dir_t            dir;
  dir_t            req_dir;
  logic            req_valid;
  logic            opposite;
  logic [5:0]      head_x;
  logic [4:0]      head_y;
  logic [6:0]      next_x;
  logic [5:0]      next_y;
  logic            collide;
  logic [CW-1:0]   step_cnt;

  always_comb begin
    req_valid = 1'b1;
    req_dir   = dir;
    if (iDir[3])      req_dir = D_UP;
    else if (iDir[2]) req_dir = D_DOWN;
    else if (iDir[1]) req_dir = D_LEFT;
    else if (iDir[0]) req_dir = D_RIGHT;
    else              req_valid = 1'b0;
    opposite = (req_dir[1] == dir[1]) && (req_dir[0] != dir[0]);
  end

  // One extra bit so that stepping below zero lands far above the grid limit.
  always_comb begin
    next_x = {1'b0, head_x};
    next_y = {1'b0, head_y};
    case (dir)
      D_UP:    next_y = {1'b0, head_y} - 6'd1;
      D_DOWN:  next_y = {1'b0, head_y} + 6'd1;
      D_LEFT:  next_x = {1'b0, head_x} - 7'd1;
      default: next_x = {1'b0, head_x} + 7'd1;
    endcase
    collide = (next_x >= 7'(GRID_W)) || (next_y >= 6'(GRID_H));
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state     <= S_IDLE;
      dir       <= D_RIGHT;
      head_x    <= 6'(START_X);
      head_y    <= 5'(START_Y);
      step_cnt  <= '0;
      oDrawReq  <= 1'b0;
      oX        <= 6'(START_X);
      oY        <= 5'(START_Y);
      oColour   <= 1'b1;
      oSpeed    <= 2'd0;
      oGameOver <= 1'b0;
    end else begin
      if (state != S_DEAD && req_valid && !opposite)
        dir <= req_dir;

      case (state)
        S_IDLE: begin
          if (iTick && iEnable) begin
            if (collide) begin
              state     <= S_DEAD;
              oGameOver <= 1'b1;
            end else begin
              state    <= S_ERASE;
              head_x   <= next_x[5:0];
              head_y   <= next_y[4:0];
              oDrawReq <= 1'b1;
              oX       <= head_x;
              oY       <= head_y;
              oColour  <= 1'b0;
            end
          end
        end
        S_ERASE: begin
          if (iDrawAck) begin
            state   <= S_DRAW;
            oX      <= head_x;
            oY      <= head_y;
            oColour <= 1'b1;
          end
        end
        S_DRAW: begin
          if (iDrawAck) begin
            state    <= S_IDLE;
            oDrawReq <= 1'b0;
            if (step_cnt == CW'(STEPS_PER_LEVEL - 1)) begin
              step_cnt <= '0;
              if (oSpeed != 2'd3)
                oSpeed <= oSpeed + 2'd1;
            end else begin
              step_cnt <= step_cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// tb/tb_snake_head_stepper.sv - scoreboard bench for snake_head_stepper
module tb_snake_head_stepper;

  logic       iClock = 1'b0;
  logic       iReset = 1'b0;
  logic       iTick = 1'b0;
  logic       iEnable = 1'b1;
  logic [3:0] iDir = 4'b0;
  logic       iDrawAck = 1'b0;
  logic       oDrawReq;
  logic [5:0] oX;
  logic [4:0] oY;
  logic       oColour;
  logic [1:0] oSpeed;
  logic       oGameOver;

  snake_head_stepper dut (
    .iClock(iClock), .iReset(iReset), .iTick(iTick), .iEnable(iEnable),
    .iDir(iDir), .iDrawAck(iDrawAck), .oDrawReq(oDrawReq), .oX(oX), .oY(oY),
    .oColour(oColour), .oSpeed(oSpeed), .oGameOver(oGameOver)
  );

  always #5 iClock = ~iClock;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  logic [5:0] hx;
  logic [4:0] hy;
  logic [3:0] hdir;
  int         moves;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  // Presets direction d (if non-zero) in IDLE, then ticks with ack held high.
  task automatic move(input logic [3:0] d, output int lat);
    logic [5:0] nx;
    logic [4:0] ny;
    if (d != 4'b0) begin
      iDir = d;
      step();
      iDir = 4'b0;
      hdir = d;
    end
    nx = hx;
    ny = hy;
    case (hdir)
      4'b1000: ny = hy - 5'd1;
      4'b0100: ny = hy + 5'd1;
      4'b0010: nx = hx - 6'd1;
      default: nx = hx + 6'd1;
    endcase
    exp_q.push_back({hx, hy, 1'b0});
    exp_q.push_back({nx, ny, 1'b1});
    iDrawAck = 1'b1;
    iTick = 1'b1;
    step();
    iTick = 1'b0;
    lat = 1;
    while (oDrawReq && lat < 20) begin
      step();
      lat++;
    end
    iDrawAck = 1'b0;
    chk("move_complete", int'(oDrawReq), 0);
    hx = nx;
    hy = ny;
    moves++;
  endtask

  // Monitor: pops an expected plot whenever a request is accepted, and checks stability while stalled.
  initial begin
    logic        prev_req;
    logic        prev_ack;
    logic [11:0] prev_pkt;
    logic [11:0] cur;
    logic [11:0] e;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_pkt = '0;
    forever begin
      @(negedge iClock);
      cur = {oX, oY, oColour};
      if (oDrawReq) begin
        if (prev_req && !prev_ack)
          chk("req_stable", int'(cur), int'(prev_pkt));
        if (iDrawAck) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_req: got x=%0d y=%0d c=%0d expected no request", oX, oY, oColour);
          end else begin
            e = exp_q.pop_front();
            if (cur != e) begin
              failures++;
              $display("FAIL plot: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                       cur[11:6], cur[5:1], cur[0], e[11:6], e[5:1], e[0]);
            end
          end
        end
      end
      prev_req = oDrawReq;
      prev_ack = iDrawAck;
      prev_pkt = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int m;
    int es;
    logic [3:0] dseq [4];
    dseq[0] = 4'b0001;
    dseq[1] = 4'b0100;
    dseq[2] = 4'b0010;
    dseq[3] = 4'b1000;

    hx = 6'd20; hy = 5'd15; hdir = 4'b0001; moves = 0;
    step();
    step();
    iReset = 1'b1;
    chk("rst_req", int'(oDrawReq), 0);
    chk("rst_x", int'(oX), 20);
    chk("rst_y", int'(oY), 15);
    chk("rst_colour", int'(oColour), 1);
    chk("rst_speed", int'(oSpeed), 0);
    chk("rst_gameover", int'(oGameOver), 0);

    move(4'b0, lat);
    chk("first_move_latency", lat, 3);
    chk("first_move_speed", int'(oSpeed), 0);
    chk("first_move_x", int'(oX), 21);

    iDir = 4'b0010;
    step();
    iDir = 4'b0;
    move(4'b0, lat);
    chk("reverse_ignored_x", int'(oX), 22);
    chk("reverse_ignored_y", int'(oY), 15);

    move(4'b1000, lat);
    chk("turn_up_x", int'(oX), 22);
    chk("turn_up_y", int'(oY), 14);

    exp_q.push_back({6'd22, 5'd14, 1'b0});
    exp_q.push_back({6'd22, 5'd13, 1'b1});
    iDrawAck = 1'b0;
    iTick = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      iTick = (c == 1 || c == 3);
      chk("stall_req", int'(oDrawReq), 1);
      chk("stall_x", int'(oX), 22);
      chk("stall_y", int'(oY), 14);
      chk("stall_colour", int'(oColour), 0);
      step();
    end
    iTick = 1'b0;
    iDrawAck = 1'b1;
    step();
    chk("stall_draw_y", int'(oY), 13);
    chk("stall_draw_colour", int'(oColour), 1);
    step();
    iDrawAck = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("dropped_tick_no_req", int'(oDrawReq), 0);
      step();
    end
    chk("stall_head_y", int'(oY), 13);
    hy = 5'd13;
    moves++;

    iEnable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      iTick = 1'b1;
      step();
      iTick = 1'b0;
      chk("paused_no_req", int'(oDrawReq), 0);
      step();
    end
    chk("paused_x", int'(oX), 22);
    chk("paused_y", int'(oY), 13);
    iEnable = 1'b1;

    exp_q.push_back({6'd22, 5'd13, 1'b0});
    exp_q.push_back({6'd22, 5'd12, 1'b1});
    iDrawAck = 1'b1;
    iTick = 1'b1;
    step();
    iTick = 1'b0;
    step();
    iDrawAck = 1'b0;
    chk("pre_reset_in_draw", int'(oDrawReq), 1);
    iReset = 1'b0;
    step();
    iReset = 1'b1;
    chk("reset_mid_req", int'(oDrawReq), 0);
    chk("reset_mid_x", int'(oX), 20);
    chk("reset_mid_y", int'(oY), 15);
    es = exp_q.size();
    chk("abandoned_draw_pending", es, 1);
    exp_q.delete();
    hx = 6'd20; hy = 5'd15; hdir = 4'b0001; moves = 0;

    // Square loop of side 4: returns to (20,15) every 16 moves.
    for (int i = 0; i < 80; i++) begin
      move((i % 4 == 0) ? dseq[(i / 4) % 4] : 4'b0, lat);
      m = i + 1;
      if (m % 16 == 0 || m % 16 == 15)
        chk($sformatf("speed_after_%0d", m), int'(oSpeed), (m / 16 > 3) ? 3 : m / 16);
    end
    chk("loop_end_x", int'(oX), 20);
    chk("loop_end_y", int'(oY), 15);

    for (int i = 0; i < 15; i++)
      move(4'b0, lat);
    chk("top_row_y", int'(oY), 0);
    chk("top_row_gameover", int'(oGameOver), 0);

    iTick = 1'b1;
    step();
    iTick = 1'b0;
    chk("collide_gameover", int'(oGameOver), 1);
    chk("collide_no_req", int'(oDrawReq), 0);
    chk("collide_x", int'(oX), 20);
    chk("collide_y", int'(oY), 0);

    iDrawAck = 1'b1;
    for (int c = 0; c < 6; c++) begin
      iTick = c[0];
      iDir = dseq[c % 4];
      step();
      chk("dead_no_req", int'(oDrawReq), 0);
      chk("dead_sticky", int'(oGameOver), 1);
      chk("dead_x", int'(oX), 20);
      chk("dead_y", int'(oY), 0);
    end
    iTick = 1'b0;
    iDir = 4'b0;
    iDrawAck = 1'b0;
    chk("dead_speed", int'(oSpeed), 3);

    step();
    es = exp_q.size();
    chk("scoreboard_drained", es, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
